// File: rtl/wb_master_bridge_pkg.sv
// Shared definitions for the Wishbone master bridge: bus widths and FSM state encodings.
package wb_master_bridge_pkg;

    localparam int          REG_BUS_W = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'b00,
        WB_BUSY       = 2'b01,
        WB_WAIT_STALL = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_master_bridge.sv
// Wishbone B3 classic single-transfer initiator for the CPU memory stage.
// Holds the pipeline in stall until ack, flush, or bus timeout ends the cycle.
//
// state         | meaning
// WB_IDLE       | no cycle open; accepts a CPU request when not flushed
// WB_BUSY       | cyc/stb asserted, waiting for ack, flush or timeout
// WB_WAIT_STALL | cycle finished, pipeline still held by another source
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int AW      = REG_BUS_W,
    parameter int DW      = REG_BUS_W,
    parameter int TIMEOUT = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          cpu_ce_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    input  logic [3:0]    cpu_sel_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          stall_req_o,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic          bus_err_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    wb_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_rbuf, w_rbuf_nxt;
    logic [AW-1:0] r_adr, w_adr_nxt;
    logic [DW-1:0] r_dat, w_dat_nxt;
    logic [3:0]    r_sel, w_sel_nxt;
    logic          r_we, w_we_nxt;
    logic          r_cyc, w_cyc_nxt;
    logic          r_err, w_err_nxt;
    logic          w_to_hit;
    logic          w_stall_req;
    logic          w_start;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= WB_IDLE;
            r_cnt   <= '0;
            r_rbuf  <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= 4'h0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rbuf  <= w_rbuf_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            r_sel   <= w_sel_nxt;
            r_we    <= w_we_nxt;
            r_cyc   <= w_cyc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign w_to_hit = (r_cnt == TO_LAST);
    assign w_start  = cpu_ce_i & ~flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rbuf_nxt  = r_rbuf;
        w_adr_nxt   = r_adr;
        w_dat_nxt   = r_dat;
        w_sel_nxt   = r_sel;
        w_we_nxt    = r_we;
        w_cyc_nxt   = r_cyc;
        w_err_nxt   = 1'b0;
        w_stall_req = 1'b0;

        unique case (r_state)
            WB_IDLE: begin
                w_stall_req = w_start;
                if (w_start) begin
                    w_adr_nxt   = cpu_addr_i;
                    w_dat_nxt   = cpu_data_i;
                    w_we_nxt    = cpu_we_i;
                    w_sel_nxt   = cpu_sel_i;
                    w_cyc_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WB_BUSY;
                end
            end
            WB_BUSY: begin
                w_stall_req = ~(wb_ack_i | w_to_hit | flush_i);
                // Address and write data are left on the bus after close; only the
                // cycle qualifiers are dropped.
                if (flush_i || wb_ack_i || w_to_hit) begin
                    w_cyc_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    w_sel_nxt = 4'h0;
                end
                if (flush_i) begin
                    w_state_nxt = WB_IDLE;
                end else if (wb_ack_i) begin
                    if (!r_we) w_rbuf_nxt = wb_dat_i;
                    w_state_nxt = stall_i ? WB_WAIT_STALL : WB_IDLE;
                end else if (w_to_hit) begin
                    w_rbuf_nxt  = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = stall_i ? WB_WAIT_STALL : WB_IDLE;
                end else if (r_cnt != TO_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WB_WAIT_STALL: begin
                if (!stall_i || flush_i) w_state_nxt = WB_IDLE;
            end
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    // A flushed cycle ignores its ack, so the bypass path is blocked too.
    assign cpu_data_o  = (r_state == WB_BUSY && wb_ack_i && !r_we && !flush_i) ? wb_dat_i : r_rbuf;
    assign stall_req_o = w_stall_req;
    assign bus_err_o   = r_err;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_we_o     = r_we;
    assign wb_sel_o    = r_sel;
    assign wb_stb_o    = r_cyc;
    assign wb_cyc_o    = r_cyc;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed per-cycle vector bench for wb_master_bridge with TIMEOUT = 8.
module tb_wb_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, we_i, flush, stall, ack;
    logic [31:0] addr, wdat, rdat;
    logic [3:0]  sel_i;
    logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
    logic        stall_req_o, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cpu_ce_i   (ce),
        .cpu_we_i   (we_i),
        .cpu_addr_i (addr),
        .cpu_data_i (wdat),
        .cpu_sel_i  (sel_i),
        .cpu_data_o (cpu_data_o),
        .stall_req_o(stall_req_o),
        .stall_i    (stall),
        .flush_i    (flush),
        .bus_err_o  (bus_err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (rdat),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (ack)
    );

    typedef struct {
        logic        ce, we, fl, st, ak;
        logic [31:0] a, d, rd;
        logic [3:0]  sl;
        logic        e_cyc, e_we, e_sreq, e_err;
        logic [31:0] e_dout, e_adr, e_wdat;
        logic [3:0]  e_sel;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic c, w, input logic [31:0] a, d, input logic [3:0] sl,
                       input logic fl, st, ak, input logic [31:0] rd,
                       input logic ecyc, ewe, esr, eerr, input logic [31:0] edout, eadr, ewd,
                       input logic [3:0] esel);
        vec_t v;
        v.ce = c; v.we = w; v.a = a; v.d = d; v.sl = sl; v.fl = fl; v.st = st; v.ak = ak; v.rd = rd;
        v.e_cyc = ecyc; v.e_we = ewe; v.e_sreq = esr; v.e_err = eerr;
        v.e_dout = edout; v.e_adr = eadr; v.e_wdat = ewd; v.e_sel = esel;
        tv.push_back(v);
    endtask

    task automatic idle_inputs();
        ce = 0; we_i = 0; addr = '0; wdat = '0; sel_i = 4'h0;
        flush = 0; stall = 0; ack = 0; rdat = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        //  ce we addr          wdata         sel  fl st ak rdata          | cyc we sreq err dout          adr           wdat          sel
        // load, 3 wait states
        add(1, 0, 32'h1000_0004, 32'h0,         4'hF, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,         32'h0,         32'h0,         4'h0);
        for (int i = 0; i < 3; i++)
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h0,         32'h1000_0004, 32'h0,         4'hF);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h1000_0004, 32'h0,         4'hF);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 32'h1000_0004, 32'h0,         4'h0);
        // store, zero-wait ack; read data on the bus must not reach the buffer
        add(1, 1, 32'h0C00_2000, 32'h2,         4'hF, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'hDEAD_BEEF, 32'h1000_0004, 32'h0,         4'h0);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 1, 32'h1234_5678, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h0C00_2000, 32'h2,         4'hF);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0C00_2000, 32'h2,         4'h0);
        // flush with simultaneous ack
        add(1, 0, 32'h2000_0000, 32'h0,         4'h1, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0C00_2000, 32'h2,         4'h0);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         1, 0, 1, 0, 32'hDEAD_BEEF, 32'h2000_0000, 32'h0,         4'h1);
        add(0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 1, 32'hCAFE_F00D, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h2000_0000, 32'h0,         4'h1);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 32'h2000_0000, 32'h0,         4'h0);
        // timeout: cyc high for exactly 8 cycles
        add(1, 0, 32'h3000_0000, 32'h0,         4'hF, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'hDEAD_BEEF, 32'h2000_0000, 32'h0,         4'h0);
        for (int i = 0; i < 7; i++)
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         1, 0, 1, 0, 32'hDEAD_BEEF, 32'h3000_0000, 32'h0,         4'hF);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'hDEAD_BEEF, 32'h3000_0000, 32'h0,         4'hF);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0,         32'h3000_0000, 32'h0,         4'h0);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h3000_0000, 32'h0,         4'h0);
        // ack while stalled: 3 cycles in WAIT_STALL, held request not reissued
        add(1, 0, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,         32'h3000_0000, 32'h0,         4'h0);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 1, 32'h55AA_55AA, 1, 0, 0, 0, 32'h55AA_55AA, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF);
        for (int i = 0; i < 2; i++)
        add(1, 0, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h55AA_55AA, 32'h4000_0000, 32'hA5A5_A5A5, 4'h0);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h55AA_55AA, 32'h4000_0000, 32'hA5A5_A5A5, 4'h0);
        add(0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h55AA_55AA, 32'h4000_0000, 32'hA5A5_A5A5, 4'h0);

        // reset values
        #3;
        check("rst_cyc",  0, 32'(wb_cyc_o),    32'h0);
        check("rst_stb",  0, 32'(wb_stb_o),    32'h0);
        check("rst_we",   0, 32'(wb_we_o),     32'h0);
        check("rst_err",  0, 32'(bus_err_o),   32'h0);
        check("rst_adr",  0, wb_adr_o,         32'h0);
        check("rst_dat",  0, wb_dat_o,         32'h0);
        check("rst_sel",  0, 32'(wb_sel_o),    32'h0);
        check("rst_dout", 0, cpu_data_o,       32'h0);
        check("rst_sreq", 0, 32'(stall_req_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            ce = tv[i].ce; we_i = tv[i].we; addr = tv[i].a; wdat = tv[i].d; sel_i = tv[i].sl;
            flush = tv[i].fl; stall = tv[i].st; ack = tv[i].ak; rdat = tv[i].rd;
            #1;
            check("cyc",  i, 32'(wb_cyc_o),    32'(tv[i].e_cyc));
            check("stb",  i, 32'(wb_stb_o),    32'(tv[i].e_cyc));
            check("we",   i, 32'(wb_we_o),     32'(tv[i].e_we));
            check("sreq", i, 32'(stall_req_o), 32'(tv[i].e_sreq));
            check("err",  i, 32'(bus_err_o),   32'(tv[i].e_err));
            check("dout", i, cpu_data_o,       tv[i].e_dout);
            check("adr",  i, wb_adr_o,         tv[i].e_adr);
            check("wdat", i, wb_dat_o,         tv[i].e_wdat);
            check("sel",  i, 32'(wb_sel_o),    32'(tv[i].e_sel));
        end

        // async reset in the middle of a BUSY cycle
        @(negedge clk);
        idle_inputs();
        ce = 1; addr = 32'h5000_0000; sel_i = 4'hF;
        @(posedge clk);
        #1 ce = 0;
        #1 check("ar_busy_cyc", 0, 32'(wb_cyc_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_cyc",  0, 32'(wb_cyc_o), 32'h0);
        check("ar_stb",  0, 32'(wb_stb_o), 32'h0);
        check("ar_adr",  0, wb_adr_o,      32'h0);
        check("ar_sel",  0, 32'(wb_sel_o), 32'h0);
        check("ar_dout", 0, cpu_data_o,    32'h0);
        @(negedge clk);
        ack = 1; rdat = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("ar_late_ack_cyc",  0, 32'(wb_cyc_o), 32'h0);
        check("ar_late_ack_dout", 0, cpu_data_o,    32'h0);
        ack = 0; rdat = '0;

        // fresh zero-wait load after reset release
        @(negedge clk);
        ce = 1; addr = 32'h6000_0008; sel_i = 4'hF;
        #1 check("fr_sreq", 0, 32'(stall_req_o), 32'h1);
        @(negedge clk);
        ce = 0; addr = '0; sel_i = 4'h0; ack = 1; rdat = 32'h0BAD_F00D;
        #1;
        check("fr_cyc",  0, 32'(wb_cyc_o),    32'h1);
        check("fr_adr",  0, wb_adr_o,         32'h6000_0008);
        check("fr_sreq", 1, 32'(stall_req_o), 32'h0);
        check("fr_dout", 0, cpu_data_o,       32'h0BAD_F00D);
        @(negedge clk);
        ack = 0; rdat = '0;
        #1;
        check("fr_cyc",  1, 32'(wb_cyc_o), 32'h0);
        check("fr_dout", 1, cpu_data_o,    32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
